instr_fetch_unit: RTL and testbench

Instruction fetch stage between the program-counter logic and the decoder. Owns the fetch PC, issues 32-bit instruction reads to instruction memory over a valid/ready request channel, buffers returned instructions with their PCs in a small queue, and presents them to decode through a valid/ready handshake. A redirect input (taken branch / jump target from execute) reloads the fetch PC, flushes buffered instructions and discards any in-flight response.

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit_queue.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int              XLEN     = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch stage bus: redirect input, instruction memory channel and decode handshake.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_resp_valid;
    logic [INSTR_W-1:0]  imem_resp_data;

    logic                if_valid;
    logic                if_ready;
    logic [XLEN-1:0]     if_pc;
    logic [INSTR_W-1:0]  if_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; head is read straight from storage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem read at a time and
// buffers responses for decode.
//
//   state | meaning
//   ------+------------------------------------------------------
//   IDLE  | nothing outstanding; request issued when queue has room
//   WAIT  | one request outstanding, response will be queued
//   DROP  | one request outstanding, response is stale and discarded
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic [XLEN-1:0]  pc_inflight_q, pc_inflight_d;

    logic             req_valid;
    logic             req_fire;
    logic             q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]    q_count;
    fetch_entry_t     q_head, q_push_data;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A response always closes the outstanding request, even alongside a redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_fire) state_d = WAIT;
            WAIT: begin
                if (bus.imem_resp_valid)     state_d = IDLE;
                else if (bus.redirect_valid) state_d = DROP;
            end
            DROP: if (bus.imem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid = !reset && (state_q == IDLE) && !q_full && !bus.redirect_valid;
        req_fire  = req_valid && bus.imem_req_ready;
        q_push    = !reset && (state_q == WAIT) && bus.imem_resp_valid && !bus.redirect_valid;

        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = fpc_q;
        bus.if_valid       = !reset && !q_empty && !bus.redirect_valid;
        bus.if_pc          = reset ? '0 : q_head.pc;
        bus.if_instr       = reset ? '0 : q_head.instr;
        q_pop              = bus.if_valid && bus.if_ready;
    end

    always_comb begin
        fpc_d         = fpc_q;
        pc_inflight_d = pc_inflight_q;
        if (bus.redirect_valid) begin
            fpc_d = align_pc(bus.redirect_pc);
        end else if (req_fire) begin
            fpc_d         = fpc_q + XLEN'(4);
            pc_inflight_d = fpc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            pc_inflight_q <= RESET_PC;
        end else begin
            fpc_q         <= fpc_d;
            pc_inflight_q <= pc_inflight_d;
        end
    end

    always_comb begin
        q_push_data.pc    = pc_inflight_q;
        q_push_data.instr = bus.imem_resp_data;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // Only one request is ever in flight and it is issued only with room left.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) q_count <= DEPTH_C);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a latency-programmable memory model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    endtask

    // Stimulus knobs
    bit          k_rst;
    bit          k_mem_ready;
    bit          k_if_ready;
    bit          k_redir;
    logic [63:0] k_redir_pc;
    int          k_lat;

    // Reference model state
    fetch_entry_t sb_q[$];
    bit           pending;
    bit           stale;
    int           wait_cnt;
    logic [63:0]  paddr;
    logic [63:0]  exp_pc;
    bit           rst_prev;
    bit           resp_now;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5EED_0F0F ^ {a[63:48], 16'h0000};
    endfunction

    task automatic cyc();
        bit exp_req;
        bit exp_ifv;
        reset              = k_rst;
        bus.imem_req_ready = k_mem_ready;
        bus.if_ready       = k_if_ready;
        bus.redirect_valid = k_redir;
        bus.redirect_pc    = k_redir_pc;
        resp_now = 1'b0;
        if (pending) begin
            if (wait_cnt <= 1) resp_now = 1'b1;
            else wait_cnt--;
        end
        bus.imem_resp_valid = resp_now;
        bus.imem_resp_data  = resp_now ? instr_of(paddr) : 32'h0;

        @(negedge clk);
        if (k_rst) begin
            check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            check_eq("rst_if_valid",  64'(bus.if_valid), 64'd0);
            check_eq("rst_if_pc",     bus.if_pc, 64'd0);
            check_eq("rst_if_instr",  64'(bus.if_instr), 64'd0);
            if (rst_prev) check_eq("rst_req_addr", bus.imem_req_addr, RESET_PC);
            if (resp_now) begin
                pending = 1'b0;
                stale   = 1'b0;
            end else if (pending) begin
                stale = 1'b1;
            end
            sb_q.delete();
            exp_pc = RESET_PC;
        end else begin
            exp_req = !pending && (sb_q.size() < DEPTH) && !k_redir;
            exp_ifv = (sb_q.size() != 0) && !k_redir;
            check_eq("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
            check_eq("if_valid",  64'(bus.if_valid), 64'(exp_ifv));
            if (exp_ifv && k_if_ready) begin
                fetch_entry_t e;
                e = sb_q.pop_front();
                check_eq("if_pc",    bus.if_pc, e.pc);
                check_eq("if_instr", 64'(bus.if_instr), 64'(e.instr));
            end
            if (resp_now) begin
                if (!k_redir && !stale) begin
                    fetch_entry_t n;
                    n.pc    = paddr;
                    n.instr = instr_of(paddr);
                    sb_q.push_back(n);
                end
                pending = 1'b0;
                stale   = 1'b0;
            end
            if (exp_req && k_mem_ready) begin
                check_eq("req_addr", bus.imem_req_addr, exp_pc);
                pending  = 1'b1;
                stale    = 1'b0;
                paddr    = exp_pc;
                wait_cnt = k_lat;
                exp_pc   = exp_pc + 64'd4;
            end
            if (k_redir) begin
                sb_q.delete();
                if (pending) stale = 1'b1;
                exp_pc = {k_redir_pc[63:2], 2'b00};
            end
        end
        rst_prev = k_rst;
        k_redir  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        k_rst = 1'b1; k_mem_ready = 1'b1; k_if_ready = 1'b1;
        k_redir = 1'b0; k_redir_pc = '0; k_lat = 1;
        pending = 1'b0; stale = 1'b0; wait_cnt = 0; paddr = '0;
        exp_pc = RESET_PC; rst_prev = 1'b0;
        reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0;   bus.if_ready = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) cyc();
        k_rst = 1'b0;
        repeat (24) cyc();

        // Decode stalls: queue fills, then drains in order
        k_if_ready = 1'b0;
        repeat (12) cyc();
        k_if_ready = 1'b1;
        repeat (10) cyc();

        // Redirect while WAIT with one entry buffered
        k_if_ready = 1'b0;
        k_lat = 3;
        guard = 0;
        while (!(pending && !stale && wait_cnt >= 2 && sb_q.size() >= 1) && guard < 40) begin
            cyc();
            guard++;
        end
        if (guard >= 40) check_eq("wait_redir_wait_timeout", 64'd0, 64'd1);
        k_redir = 1'b1;
        k_redir_pc = 64'h1002;
        cyc();
        k_if_ready = 1'b1;
        repeat (12) cyc();

        // Redirect coinciding with a response and a decode pop
        k_if_ready = 1'b0;
        k_lat = 2;
        guard = 0;
        while (!(pending && !stale && wait_cnt <= 1 && sb_q.size() >= 1) && guard < 40) begin
            cyc();
            guard++;
        end
        if (guard >= 40) check_eq("wait_redir_resp_timeout", 64'd0, 64'd1);
        k_redir = 1'b1;
        k_redir_pc = 64'h2000;
        k_if_ready = 1'b1;
        cyc();
        repeat (10) cyc();

        // Fetch PC wraps past the top of the address space
        k_lat = 1;
        k_redir = 1'b1;
        k_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        repeat (10) cyc();

        // Reset while WAIT; the orphaned response lands during reset
        k_lat = 3;
        guard = 0;
        while (!(pending && !stale && wait_cnt >= 2) && guard < 40) begin
            cyc();
            guard++;
        end
        if (guard >= 40) check_eq("wait_reset_timeout", 64'd0, 64'd1);
        k_rst = 1'b1;
        repeat (4) cyc();
        k_rst = 1'b0;
        k_lat = 1;
        repeat (12) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
